rr_lock_arbiter: RTL
====================

# rr_lock_arbiter

Round-robin arbiter with grant locking and bounded hold time. It shares one downstream resource (bus port, memory bank, or engine) among `WIDTH` requesters. A grant stays with its owner for as long as the owner keeps its request high, up to `MAX_HOLD` cycles if others are waiting. The grant then passes to the next requester in rotating order. It sits in the arbitration library next to the fixed-priority `bitscan` block and reuses that block as its priority-pick primitive.

## Interface
- `WIDTH`, 16: number of requesters, ≥2.
- `MAX_HOLD`, 0: maximum consecutive grant cycles while another request is pending. 0 disables preemption.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  WIDTH  request vector. `req[i]` stays high for the whole time requester i uses the resource.
- `grant`  out  WIDTH  registered one-hot grant, all-zero when idle.
- `grant_valid`  out  1  registered, equals `|grant`.
- `grant_id`  out  ID_W = $clog2(WIDTH)  registered binary index of the granted requester, 0 when idle.
- `preempt`  out  1  registered one-cycle pulse, high in the first cycle of a grant that was taken from an owner by hold expiry.

## Operation
- States: IDLE (no grant) and OWNED (one grant bit set).
- Pointer `last`: one-hot register holding the most recently granted index. Reset value is bit WIDTH-1, so index 0 has top priority after reset.
- Rotation mask: `mask = ~((last << 1) - 1)`, which selects indices strictly above `last`.
- Winner selection for a candidate vector `c`:
  - If `c & mask` is nonzero, the winner is the lowest set bit of `c & mask`.
  - Otherwise, the winner is the lowest set bit of `c`.
- IDLE:
  - If `req` is nonzero, at the next edge `grant` = winner(`req`) and the state goes to OWNED.
  - Otherwise the state stays IDLE.
- OWNED, normal path:
  - The owner's req stays high and hold has not expired: the grant holds.
  - The owner's req falls: at the next edge `grant` = winner(`req & ~grant`). No idle bubble. If that vector is zero, go to IDLE.
- OWNED, preemption:
  - Condition: `MAX_HOLD` ≠ 0, `hold_cnt == MAX_HOLD-1`, owner req high, and `req & ~grant` nonzero.
  - At the next edge `grant` = winner(`req & ~grant`) and `preempt` pulses.
  - The preempted owner keeps its req high and re-enters rotation like any other requester.
- `hold_cnt`:
  - Width is $clog2(MAX_HOLD+1), minimum 1 bit.
  - Cleared on every new grant.
  - Increments each OWNED cycle and saturates at MAX_HOLD-1.
  - Increments only while other requests are pending, and holds its value otherwise, so a lone owner is never preempted.
- `last` updates to the new grant on every grant change, never to zero.
- Requests from non-owners may rise and fall freely. Only the owner's req is protocol-bound.

## Timing
- Request to grant latency is 1 cycle: `req` sampled at edge N, `grant` visible after edge N.
- Handover takes 1 cycle: owner req low in cycle N, new grant in cycle N+1.
- Grant is never asserted for a requester whose req was low at the sampling edge.
- Simultaneous owner release and hold expiry: treat as a release, so `preempt` stays 0.
- A request arriving in the same cycle as a release is eligible immediately.
- `rst` asserted at any time: `grant`, `grant_valid`, `grant_id`, `preempt`, `hold_cnt` are 0, state is IDLE, and `last` is bit WIDTH-1, all asynchronously. The first grant after deassertion follows the IDLE rule.
- All outputs are driven directly from flops. Combinational depth is two `bitscan` stages plus a mux.

## Structure
- Package `arb_pkg` holds:
  - the state enum type (IDLE, OWNED);
  - a function `onehot2bin` used for `grant_id`.
- Sub-module: two `bitscan` instances, one for the masked candidate vector and one for the unmasked candidate vector. The result is selected by the masked vector being nonzero.
- Mask generation, the hold counter, and the grant/pointer registers live in `rr_lock_arbiter` itself.

## Test plan
All scenarios use WIDTH=4 and MAX_HOLD=4.
- **Reset priority:** `req`=4'b1111 after reset → `grant`=0001, `grant_id`=0, one cycle later.
- **Rotation:** owners each hold req for 2 cycles and then drop it, all 4 requesting → grants in order 0001, 0010, 0100, 1000, 0001, with no idle cycle between them.
- **Lock:** `req`=0010 held for 20 cycles alone → `grant`=0010 throughout and `preempt` never asserts.
- **Preemption:** owner 0001 holds while `req[2]` rises at grant cycle 1 → `grant`=0100 after the 4th owned cycle with contending request, `preempt`=1 for exactly one cycle, then 0001 regains the grant after 0100 drops.
- **Wrap and mask:** `last`=1000 and `req`=0110 → `grant`=0010. Then with `last`=0010 and `req`=0101 → `grant`=0100.
- **Reset mid-grant:** `rst` pulsed while `grant`=0100 → all outputs 0 immediately. After release with `req`=1100, the grant is 0100.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitration library.
// onehot2bin covers vectors up to OH_MAX_W bits, which bounds the arbiter width.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int unsigned OH_MAX_W = 256;

  function automatic logic [7:0] onehot2bin(input logic [OH_MAX_W-1:0] oh);
    logic [7:0] bin;
    bin = '0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) bin |= 8'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/bitscan.sv
// Fixed-priority pick: returns the lowest set bit of req_i as a one-hot vector.
module bitscan #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] gnt_o
);

  // Two's complement isolates the lowest set bit; zero input gives zero output.
  assign gnt_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking and an optional bounded hold time.
// All outputs are registered; the pick is two bitscan stages plus a mux.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int MAX_HOLD = 0,
  localparam int ID_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             preempt
);

  localparam int              HC_W       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit              PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [WIDTH-1:0] LAST_RST  = {1'b1, {(WIDTH-1){1'b0}}};

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             preempt_q, preempt_d;
  logic             grant_valid_q;
  logic [ID_W-1:0]  grant_id_q;

  logic [WIDTH-1:0] cand, mask, masked, win_masked, win_full, winner;
  logic             owner_req, others;

  // The owner is excluded so a release or preemption always hands over to someone else.
  assign cand      = req & ~grant_q;
  assign mask      = ~((last_q << 1) - WIDTH'(1));
  assign masked    = cand & mask;
  assign owner_req = |(req & grant_q);
  assign others    = |cand;

  bitscan #(.WIDTH(WIDTH)) u_scan_masked (
    .req_i (masked),
    .gnt_o (win_masked)
  );

  bitscan #(.WIDTH(WIDTH)) u_scan_full (
    .req_i (cand),
    .gnt_o (win_full)
  );

  assign winner = (|masked) ? win_masked : win_full;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (others) begin
          grant_d = winner;
          last_d  = winner;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          // Release wins over a simultaneous hold expiry, so no preempt here.
          hold_d = '0;
          if (others) begin
            grant_d = winner;
            last_d  = winner;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && others) begin
          grant_d   = winner;
          last_d    = winner;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (others && (hold_q != HOLD_LAST)) begin
          // Counting only under contention keeps a lone owner from ever expiring.
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_q        <= LAST_RST;
      hold_q        <= '0;
      preempt_q     <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      preempt_q     <= preempt_d;
      grant_valid_q <= |grant_d;
      grant_id_q    <= ID_W'(onehot2bin(OH_MAX_W'(grant_d)));
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign preempt     = preempt_q;

endmodule
